// File: rtl/logic_exec_stage_pkg.sv
// Shared definitions for the logic execute stage: opcodes, FSM states,
// default widths and the state chosen when an operation is accepted.
package exec_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int TAG_W_DEF   = 5;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // A shift by zero completes like any single-cycle op; only a nonzero
  // shift amount needs the iterative SHIFT state.
  function automatic state_t accept_state(input logic [2:0] op, input logic shamt_zero);
    return ((op == OP_SHL) && !shamt_zero) ? ST_SHIFT : ST_HOLD;
  endfunction

endpackage

// File: rtl/logic_exec_stage_logic_unit.sv
// Combinational bitwise unit: maps op/a/b to the result for ops 0-6.
// SHL (op 7) returns a unchanged, which is exactly the result of a shift
// by zero, so the stage can load this output for every zero-latency op.
module logic_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_res;

      // Per-bit primitive selection; every opcode is defined.
      always_comb begin
        bit_res = a[gi];
        case (op)
          OP_AND:  bit_res = a[gi] & b[gi];
          OP_OR:   bit_res = a[gi] | b[gi];
          OP_XOR:  bit_res = a[gi] ^ b[gi];
          OP_NOT:  bit_res = ~a[gi];
          OP_NAND: bit_res = ~(a[gi] & b[gi]);
          OP_NOR:  bit_res = ~(a[gi] | b[gi]);
          OP_PASS: bit_res = a[gi];
          default: bit_res = a[gi];
        endcase
      end

      assign result[gi] = bit_res;
    end
  endgenerate

endmodule

// File: rtl/logic_exec_stage.sv
// Registered execute stage: valid/ready input, bitwise ops with one-cycle
// latency, iterative left shift that stalls the input, and a held result
// register with zero flag and tag toward writeback.
module logic_exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [SHAMT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               zero_reg, zero_next;
  logic [TAG_W-1:0]   tag_reg, tag_next;

  logic [WIDTH-1:0]   lu_result;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (lu_result)
  );

  assign shamt   = in_b[SHAMT_W-1:0];
  assign shifted = shift_reg << 1;

  // Ready is a pure function of state and downstream ready, never of in_valid.
  assign in_ready = (state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid  = (state_reg == ST_HOLD);
  assign busy       = (state_reg == ST_SHIFT);
  assign out_result = result_reg;
  assign out_zero   = zero_reg;
  assign out_tag    = tag_reg;

  // Next-state and datapath update; registers hold their value by default,
  // which is what keeps the outputs frozen while HOLD is stalled.
  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    count_next  = count_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    tag_next    = tag_reg;

    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          // Loading a new op in HOLD replaces the consumed result in the
          // same edge, giving zero-bubble back-to-back issue.
          state_next = accept_state(in_op, shamt == '0);
          shift_next = in_a;
          count_next = shamt;
          tag_next   = in_tag;
          if (accept_state(in_op, shamt == '0) == ST_HOLD) begin
            result_next = lu_result;
            zero_next   = (lu_result == '0);
          end
        end else if ((state_reg == ST_HOLD) && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_next = shifted;
        count_next = count_reg - SHAMT_W'(1);
        // The counter reaches zero on this edge: publish the final value.
        if (count_reg == SHAMT_W'(1)) begin
          state_next  = ST_HOLD;
          result_next = shifted;
          zero_next   = (shifted == '0);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      count_reg  <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      tag_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      count_reg  <= count_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      tag_reg    <= tag_next;
    end
  end

endmodule

// File: tb/tb_logic_exec_stage.sv
// Directed bench for logic_exec_stage with hand-computed expectations.
module tb_logic_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic_exec_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one SHL and measures edges until out_valid, busy cycles and
  // cycles where in_ready was wrongly high during SHIFT. Bounded at 40.
  task automatic do_shl(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        output int lat, output int busy_n, output int rdy_bad);
    lat = 0; busy_n = 0; rdy_bad = 0;
    in_valid = 1'b1; in_op = 3'd7; in_a = a; in_b = b; in_tag = tag;
    out_ready = 1'b1;
    do begin
      step();
      if (lat == 0) in_valid = 1'b0;
      lat++;
      if (busy) begin
        busy_n++;
        if (in_ready) rdy_bad++;
      end
    end while (!out_valid && lat < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", out_result); end
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", out_zero); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", out_tag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    step();
    $display("reset: valid=%b result=%h zero=%b busy=%b", out_valid, out_result, out_zero, busy);
  endtask

  task automatic test_and();
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'hA5A5A5A5; in_b = 32'h0F0F0F0F; in_tag = 5'd3;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL and_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    $display("and: valid=%b result=%h zero=%b tag=%0d", out_valid, out_result, out_zero, out_tag);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL and_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== 32'h05050505) begin bad++; $display("FAIL and_result got=%h exp=05050505", out_result); end
    total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL and_zero got=%b exp=0", out_zero); end
    total++; if (out_tag !== 5'd3) begin bad++; $display("FAIL and_tag got=%0d exp=3", out_tag); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL and_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_res [6] = '{32'hAFAFAFAF, 32'hAAAAAAAA, 32'h5A5A5A5A,
                                 32'hFAFAFAFA, 32'h50505050, 32'hA5A5A5A5};
    in_a = 32'hA5A5A5A5; in_b = 32'h0F0F0F0F; out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd1; in_tag = 5'd1;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready op=%0d got=%b exp=1", i + 1, in_ready); end
      step();
      $display("b2b op=%0d: valid=%b result=%h tag=%0d", i + 1, out_valid, out_result, out_tag);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid op=%0d got=%b exp=1", i + 1, out_valid); end
      total++; if (out_result !== exp_res[i]) begin bad++; $display("FAIL b2b_result op=%0d got=%h exp=%h", i + 1, out_result, exp_res[i]); end
      total++; if (out_tag !== 5'(i + 1)) begin bad++; $display("FAIL b2b_tag op=%0d got=%0d exp=%0d", i + 1, out_tag, i + 1); end
      if (i < 5) begin
        in_op = 3'(i + 2); in_tag = 5'(i + 2);
      end else begin
        in_valid = 1'b0;
      end
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_tag = 5'd4;
    out_ready = 1'b0;
    step();
    // A second op waits at the input while the result is stalled.
    in_op = 3'd0; in_a = 32'h1; in_b = 32'h1; in_tag = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("hold cyc=%0d: valid=%b result=%h zero=%b ready=%b", i, out_valid, out_result, out_zero, in_ready);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
      total++; if (out_result !== 32'h0) begin bad++; $display("FAIL hold_result cyc=%0d got=%h exp=0", i, out_result); end
      total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL hold_zero cyc=%0d got=%b exp=1", i, out_zero); end
      total++; if (out_tag !== 5'd4) begin bad++; $display("FAIL hold_tag cyc=%0d got=%0d exp=4", i, out_tag); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    $display("hold release: valid=%b result=%h tag=%0d", out_valid, out_result, out_tag);
    total++; if (out_result !== 32'h1) begin bad++; $display("FAIL hold_next_result got=%h exp=1", out_result); end
    total++; if (out_tag !== 5'd9) begin bad++; $display("FAIL hold_next_tag got=%0d exp=9", out_tag); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_shift();
    logic [31:0] va [5] = '{32'h00000001, 32'hDEADBEEF, 32'h00000003, 32'h00000002, 32'h00000001};
    logic [31:0] vb [5] = '{32'd31,       32'hFFFFFFE0, 32'd31,       32'd31,       32'd4};
    logic [31:0] vr [5] = '{32'h80000000, 32'hDEADBEEF, 32'h80000000, 32'h00000000, 32'h00000010};
    int          vl [5] = '{32, 1, 32, 32, 5};
    logic        vz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, busy_n, rdy_bad;
    for (int i = 0; i < 5; i++) begin
      do_shl(va[i], vb[i], 5'(10 + i), lat, busy_n, rdy_bad);
      $display("shl a=%h b=%0d: lat=%0d busy=%0d result=%h zero=%b tag=%0d",
               va[i], vb[i][4:0], lat, busy_n, out_result, out_zero, out_tag);
      total++; if (lat !== vl[i]) begin bad++; $display("FAIL shl_latency %0d got=%0d exp=%0d", i, lat, vl[i]); end
      total++; if (busy_n !== vl[i] - 1) begin bad++; $display("FAIL shl_busy %0d got=%0d exp=%0d", i, busy_n, vl[i] - 1); end
      total++; if (rdy_bad !== 0) begin bad++; $display("FAIL shl_ready %0d got=%0d exp=0", i, rdy_bad); end
      total++; if (out_result !== vr[i]) begin bad++; $display("FAIL shl_result %0d got=%h exp=%h", i, out_result, vr[i]); end
      total++; if (out_zero !== vz[i]) begin bad++; $display("FAIL shl_zero %0d got=%b exp=%b", i, out_zero, vz[i]); end
      total++; if (out_tag !== 5'(10 + i)) begin bad++; $display("FAIL shl_tag %0d got=%0d exp=%0d", i, out_tag, 10 + i); end
      step();
    end
  endtask

  task automatic test_reset_mid_shift();
    in_valid = 1'b1; in_op = 3'd7; in_a = 32'h1; in_b = 32'd31; in_tag = 5'd2; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    // Now in the 1st SHIFT cycle; advance to the 10th.
    repeat (9) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy got=%b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid-shift reset: busy=%b valid=%b result=%h zero=%b", busy, out_valid, out_result, out_zero);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h exp=0", out_result); end
    total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL midrst_zero got=%b exp=1", out_zero); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'hFF00FF00; in_b = 32'h0F0F0F0F; in_tag = 5'd6;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL postrst_pre_valid got=%b exp=0", out_valid); end
    step();
    in_valid = 1'b0;
    $display("post-reset and: valid=%b result=%h tag=%0d", out_valid, out_result, out_tag);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL postrst_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== 32'h0F000F00) begin bad++; $display("FAIL postrst_result got=%h exp=0F000F00", out_result); end
    total++; if (out_tag !== 5'd6) begin bad++; $display("FAIL postrst_tag got=%0d exp=6", out_tag); end
    step();
  endtask

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_hold();
    test_shift();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
